dg0050_pc_stack: RTL and testbench
==================================

DG0050_PC_STACK -- requirements
Module: dg0050_pc_stack

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-002 Parameter PL_W, default 6, SHALL set the width of the in-page polynomial counter PL.
REQ-003 Parameter PU_W, default 4, SHALL set the width of the page register PU.
REQ-004 Parameter STACK_DEPTH, default 5, range 1..16, SHALL set the number of return-stack entries.
REQ-005 Parameter CALL_PAGE, default all ones, SHALL set the PU value loaded by CALL.
REQ-006 Ports, listed as name, direction, width, meaning:
- clk  in  1  system clock, posedge active.
- rst_n  in  1  asynchronous active-low reset.
- cmd_i  in  3  PC command; 0 NEXT, 1 JMP, 2 LJMP, 3 CALL, 4 RET, 5 RETSK, 6 HOLD, 7 treated as NEXT.
- target_i  in  PU_W+PL_W  jump/call target; JMP and CALL use the low PL_W bits only.
- flag_clr_i  in  1  clears the sticky stack flags.
- pc_o  out  PU_W+PL_W  current PC, {PU,PL}.
- phase_o  out  3  machine-cycle phase, 0..7.
- cyc_end_o  out  1  high when phase_o==7.
- depth_o  out  5  number of valid stack entries, 0..STACK_DEPTH.
- skip_o  out  1  next-instruction suppress.
- stk_ovf_o  out  1  sticky overflow flag.
- stk_unf_o  out  1  sticky underflow flag.

Function
REQ-007 A 3-bit phase counter SHALL increment on every clk edge and wrap from 7 to 0; one machine cycle SHALL be 8 clks.
REQ-008 All PC, stack, skip and flag state SHALL update only on the clk edge where phase_o==7, and SHALL not use gated or derived clocks.
REQ-009 cmd_i, target_i and flag_clr_i SHALL be sampled at the phase-7 edge; the result SHALL be visible on pc_o from phase 0 of the next cycle, a latency of 1 clk.
REQ-010 The NEXT step SHALL be: PL <= {~(PL[0]^PL[1]), PL[PL_W-1:1]}, with PU unchanged.
REQ-011 JMP SHALL set PL <= target_i[PL_W-1:0] and keep PU; LJMP SHALL set {PU,PL} <= target_i.
REQ-012 CALL SHALL push {PU, NEXT(PL)} and then set {PU,PL} <= {CALL_PAGE, target_i[PL_W-1:0]}.
REQ-013 On a push, the entries SHALL shift down one position and the top SHALL receive the new value; depth_o SHALL increment, saturating at STACK_DEPTH.
REQ-014 A push when depth_o==STACK_DEPTH SHALL discard the bottom entry and set stk_ovf_o.
REQ-015 RET and RETSK SHALL load {PU,PL} from the top entry; the entries SHALL shift up one position, the bottom SHALL fill with 0, and depth_o SHALL decrement.
REQ-016 A pop when depth_o==0 SHALL load PC 0, keep depth_o at 0, and set stk_unf_o.
REQ-017 RETSK SHALL assert skip_o for the following machine cycle, exactly 8 clks; any other command SHALL clear skip_o at the next cycle end.
REQ-018 HOLD SHALL leave PC and the stack unchanged.
REQ-019 If flag_clr_i and a new overflow or underflow event fall on the same cycle end, the set SHALL win.

Reset
REQ-020 rst_n low SHALL immediately force phase_o=0, pc_o=0, all stack entries=0, depth_o=0, skip_o=0, stk_ovf_o=0 and stk_unf_o=0, including when asserted mid-cycle.
REQ-021 After rst_n deasserts, the first phase-7 edge SHALL occur on the 8th clk.

Configuration
REQ-022 With macro PCSTK_ERR_FLAGS_EN defined, stk_ovf_o and stk_unf_o SHALL behave as in REQ-014, REQ-016 and REQ-019.
REQ-023 Without PCSTK_ERR_FLAGS_EN, stk_ovf_o and stk_unf_o SHALL be constant 0, flag_clr_i SHALL be ignored, and all other behaviour SHALL be identical.

Verification
REQ-024 Reset, then NEXT for 3 cycles -> PL goes 000000, 100000, 110000, 111000; pc_o changes only in the clk after cyc_end_o.
REQ-025 Starting from pc {0x2,0x05}, CALL with target 0x15 -> pc_o={0xF,0x15}, depth_o=1; then RET -> pc_o={0x2,0x02}, depth_o=0.
REQ-026 6 CALLs with defaults -> depth_o=5 and stk_ovf_o=1; then 6 RETs -> the first 5 RETs return the last 5 pushed addresses in reverse order, and the 6th RET returns 0 and sets stk_unf_o.
REQ-027 RETSK followed by NEXT -> skip_o high for exactly 8 clks; flag_clr_i together with an overflowing CALL -> stk_ovf_o stays 1.
REQ-028 LJMP with target 0x3A5, then rst_n pulsed at phase 3 -> pc_o=0 and phase_o=0 immediately.
REQ-029 Build without PCSTK_ERR_FLAGS_EN and repeat REQ-026 -> both flags stay 0 while PC and depth behave identically.

Source files
------------

// File: rtl/dg0050_pc_stack.sv
// Program counter with polynomial in-page counter, page register and return stack.
// Sticky stack overflow/underflow flags are built only with PCSTK_ERR_FLAGS_EN.
module dg0050_pc_stack #(
  parameter int unsigned     PL_W        = 6,
  parameter int unsigned     PU_W        = 4,
  parameter int unsigned     STACK_DEPTH = 5,
  parameter logic [PU_W-1:0] CALL_PAGE   = '1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           cmd_i,
  input  logic [PU_W+PL_W-1:0] target_i,
  input  logic                 flag_clr_i,
  output logic [PU_W+PL_W-1:0] pc_o,
  output logic [2:0]           phase_o,
  output logic                 cyc_end_o,
  output logic [4:0]           depth_o,
  output logic                 skip_o,
  output logic                 stk_ovf_o,
  output logic                 stk_unf_o
);

  localparam int unsigned PC_W    = PU_W + PL_W;
  localparam int unsigned DEPTH_W = 5;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    CMD_NEXT  = 3'd0,
    CMD_JMP   = 3'd1,
    CMD_LJMP  = 3'd2,
    CMD_CALL  = 3'd3,
    CMD_RET   = 3'd4,
    CMD_RETSK = 3'd5,
    CMD_HOLD  = 3'd6,
    CMD_RSVD  = 3'd7
  } cmd_t;

  cmd_t               cmd;
  logic [2:0]         phase_q;
  logic               cyc_end_q;
  logic [PC_W-1:0]    pc_q, pc_n;
  logic [PC_W-1:0]    stk_q [STACK_DEPTH];
  logic [PC_W-1:0]    stk_n [STACK_DEPTH];
  logic [DEPTH_W-1:0] depth_q, depth_n;
  logic               skip_q;
  logic               ovf_ev, unf_ev;
  logic [PL_W-1:0]    pl_step;
  logic               step_en;

  assign cmd     = cmd_t'(cmd_i);
  assign step_en = (phase_q == 3'd7);
  assign pl_step = {~(pc_q[0] ^ pc_q[1]), pc_q[PL_W-1:1]};

  // Machine-cycle phase; cyc_end is registered one phase ahead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= 3'd0;
      cyc_end_q <= 1'b0;
    end else begin
      phase_q   <= phase_q + 3'd1;
      cyc_end_q <= (phase_q == 3'd6);
    end
  end

  // Next PC and stack contents for the command sampled at cycle end.
  always_comb begin
    pc_n    = pc_q;
    stk_n   = stk_q;
    depth_n = depth_q;
    ovf_ev  = 1'b0;
    unf_ev  = 1'b0;
    case (cmd)
      CMD_JMP:  pc_n = {pc_q[PC_W-1:PL_W], target_i[PL_W-1:0]};
      CMD_LJMP: pc_n = target_i;
      CMD_CALL: begin
        for (int i = 1; i < int'(STACK_DEPTH); i++) stk_n[i] = stk_q[i-1];
        stk_n[0] = {pc_q[PC_W-1:PL_W], pl_step};
        pc_n     = {CALL_PAGE, target_i[PL_W-1:0]};
        if (depth_q == DEPTH_MAX) ovf_ev = 1'b1;
        else depth_n = depth_q + 5'd1;
      end
      CMD_RET, CMD_RETSK: begin
        for (int i = 0; i < int'(STACK_DEPTH) - 1; i++) stk_n[i] = stk_q[i+1];
        stk_n[STACK_DEPTH-1] = '0;
        if (depth_q == 5'd0) begin
          pc_n   = '0;
          unf_ev = 1'b1;
        end else begin
          pc_n    = stk_q[0];
          depth_n = depth_q - 5'd1;
        end
      end
      CMD_HOLD: pc_n = pc_q;
      default:  pc_n = {pc_q[PC_W-1:PL_W], pl_step};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      stk_q   <= '{default: '0};
      depth_q <= '0;
      skip_q  <= 1'b0;
    end else if (step_en) begin
      pc_q    <= pc_n;
      stk_q   <= stk_n;
      depth_q <= depth_n;
      skip_q  <= (cmd == CMD_RETSK);
    end
  end

`ifdef PCSTK_ERR_FLAGS_EN
  logic ovf_q, unf_q;

  // Sticky flags; a new event outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (step_en) begin
      ovf_q <= ovf_ev | (ovf_q & ~flag_clr_i);
      unf_q <= unf_ev | (unf_q & ~flag_clr_i);
    end
  end

  assign stk_ovf_o = ovf_q;
  assign stk_unf_o = unf_q;
`else
  logic unused_flags;
  assign unused_flags = ^{flag_clr_i, ovf_ev, unf_ev};
  assign stk_ovf_o    = 1'b0;
  assign stk_unf_o    = 1'b0;
`endif

  assign pc_o      = pc_q;
  assign phase_o   = phase_q;
  assign cyc_end_o = cyc_end_q;
  assign depth_o   = depth_q;
  assign skip_o    = skip_q;

endmodule

// File: tb/tb_dg0050_pc_stack.sv
// Directed bench for dg0050_pc_stack with a queue-based reference model.
module tb_dg0050_pc_stack;

`ifdef PCSTK_ERR_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] cmd_i = 3'd0;
  logic [9:0] target_i = 10'd0;
  logic       flag_clr_i = 1'b0;
  logic [9:0] pc_o;
  logic [2:0] phase_o;
  logic       cyc_end_o;
  logic [4:0] depth_o;
  logic       skip_o, stk_ovf_o, stk_unf_o;

  dg0050_pc_stack dut (
    .clk(clk), .rst_n(rst_n), .cmd_i(cmd_i), .target_i(target_i),
    .flag_clr_i(flag_clr_i), .pc_o(pc_o), .phase_o(phase_o),
    .cyc_end_o(cyc_end_o), .depth_o(depth_o), .skip_o(skip_o),
    .stk_ovf_o(stk_ovf_o), .stk_unf_o(stk_unf_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: clock-count phase, integer PC halves, queue stack (front = top).
  int m_phase = 0;
  int m_pu = 0;
  int m_pl = 0;
  int m_stk[$];
  bit m_skip = 0, m_ovf = 0, m_unf = 0;

  function automatic int poly_next(input int pl);
    return ((((pl ^ (pl >> 1)) & 1) ^ 1) << 5) | (pl >> 1);
  endfunction

  function automatic void model_apply(input int c, input int t, input bit clr);
    bit ov = 0, un = 0;
    case (c)
      1: m_pl = t & 63;
      2: begin m_pu = (t >> 6) & 15; m_pl = t & 63; end
      3: begin
        m_stk.push_front(m_pu * 64 + poly_next(m_pl));
        if (m_stk.size() > 5) begin void'(m_stk.pop_back()); ov = 1; end
        m_pu = 15; m_pl = t & 63;
      end
      4, 5: begin
        if (m_stk.size() == 0) begin m_pu = 0; m_pl = 0; un = 1; end
        else begin
          int v;
          v = m_stk.pop_front();
          m_pu = v / 64; m_pl = v % 64;
        end
      end
      6: ;
      default: m_pl = poly_next(m_pl);
    endcase
    m_skip = (c == 5);
    if (FLAGS_EN) begin
      m_ovf = ov | (m_ovf & !clr);
      m_unf = un | (m_unf & !clr);
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_pu = 0; m_pl = 0; m_stk.delete();
      m_skip = 0; m_ovf = 0; m_unf = 0;
    end else begin
      if (m_phase == 7) model_apply(int'(cmd_i), int'(target_i), flag_clr_i);
      m_phase = (m_phase + 1) % 8;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc",      32'(pc_o),      32'(m_pu * 64 + m_pl));
      check("phase",   32'(phase_o),   32'(m_phase));
      check("cyc_end", 32'(cyc_end_o), 32'(m_phase == 7));
      check("depth",   32'(depth_o),   32'(m_stk.size()));
      check("skip",    32'(skip_o),    32'(m_skip));
      check("ovf",     32'(stk_ovf_o), 32'(m_ovf));
      check("unf",     32'(stk_unf_o), 32'(m_unf));
    end
  end

  // Present a command ahead of the next phase-7 edge and return just after it.
  task automatic do_cmd(input logic [2:0] c, input logic [9:0] t, input logic clr);
    int n = 0;
    @(negedge clk);
    while (m_phase != 7 && n < 16) begin
      @(negedge clk);
      n++;
    end
    check("sync_timeout", 32'(n < 16), 32'd1);
    cmd_i = c; target_i = t; flag_clr_i = clr;
    @(negedge clk);
    flag_clr_i = 1'b0;
  endtask

  logic [9:0] call_ret[6] = '{10'h3C2, 10'h3E2, 10'h3E1, 10'h3C1, 10'h3C0, 10'h000};
  logic [9:0] call_pc[6]  = '{10'h3C1, 10'h3C2, 10'h3C3, 10'h3C4, 10'h3C5, 10'h3C6};

  initial begin
    int cnt;
    int n;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_pc", 32'(pc_o), 32'h0);
    check("rst_phase", 32'(phase_o), 32'h0);
    check("rst_depth", 32'(depth_o), 32'h0);
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("first_ph7_phase", 32'(phase_o), 32'd7);
    check("first_ph7_pc_unchanged", 32'(pc_o), 32'h0);

    // Polynomial NEXT sequence
    do_cmd(3'd0, 10'h0, 1'b0); check("next1", 32'(pc_o), 32'h020);
    do_cmd(3'd0, 10'h0, 1'b0); check("next2", 32'(pc_o), 32'h030);
    do_cmd(3'd0, 10'h0, 1'b0); check("next3", 32'(pc_o), 32'h038);

    // CALL / RET round trip
    do_cmd(3'd2, 10'h085, 1'b0); check("ljmp", 32'(pc_o), 32'h085);
    do_cmd(3'd3, 10'h015, 1'b0);
    check("call_pc", 32'(pc_o), 32'h3D5);
    check("call_depth", 32'(depth_o), 32'd1);
    do_cmd(3'd4, 10'h0, 1'b0);
    check("ret_pc", 32'(pc_o), 32'h082);
    check("ret_depth", 32'(depth_o), 32'd0);
    do_cmd(3'd1, 10'h3FF, 1'b0); check("jmp_keeps_pu", 32'(pc_o), 32'h0BF);

    // Overflow and underflow
    do_cmd(3'd2, 10'h000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      do_cmd(3'd3, 10'(i + 1), 1'b0);
      check("call_seq_pc", 32'(pc_o), 32'(call_pc[i]));
    end
    check("ovf_depth", 32'(depth_o), 32'd5);
    check("ovf_flag", 32'(stk_ovf_o), 32'(FLAGS_EN));
    for (int i = 0; i < 6; i++) begin
      do_cmd(3'd4, 10'h0, 1'b0);
      check("ret_seq_pc", 32'(pc_o), 32'(call_ret[i]));
    end
    check("unf_depth", 32'(depth_o), 32'd0);
    check("unf_flag", 32'(stk_unf_o), 32'(FLAGS_EN));

    // RETSK skip window
    do_cmd(3'd5, 10'h0, 1'b0);
    cmd_i = 3'd0;
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      if (skip_o) cnt++;
      @(negedge clk);
    end
    check("skip_len", 32'(cnt), 32'd8);

    // Clear, then set-wins on an overflowing CALL with clear
    do_cmd(3'd6, 10'h0, 1'b1);
    check("clr_ovf", 32'(stk_ovf_o), 32'd0);
    check("clr_unf", 32'(stk_unf_o), 32'd0);
    for (int i = 0; i < 5; i++) do_cmd(3'd3, 10'(i), 1'b0);
    check("pre_ovf", 32'(stk_ovf_o), 32'd0);
    do_cmd(3'd3, 10'h02A, 1'b1);
    check("set_wins", 32'(stk_ovf_o), 32'(FLAGS_EN));
    do_cmd(3'd7, 10'h0, 1'b0); check("cmd7_next", 32'(pc_o), 32'h3D5);

    // Mid-cycle reset
    do_cmd(3'd2, 10'h3A5, 1'b0); check("ljmp_3a5", 32'(pc_o), 32'h3A5);
    n = 0;
    while (m_phase != 3 && n < 16) begin
      @(negedge clk);
      n++;
    end
    check("ph3_timeout", 32'(n < 16), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pc", 32'(pc_o), 32'h0);
    check("mid_rst_phase", 32'(phase_o), 32'h0);
    check("mid_rst_depth", 32'(depth_o), 32'h0);
    check("mid_rst_ovf", 32'(stk_ovf_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("rst2_ph7", 32'(phase_o), 32'd7);
    check("rst2_cyc_end", 32'(cyc_end_o), 32'd1);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
